// File: rtl/clock_gen_if.sv
// Control inputs and generated clocks/ticks shared between clock_gen and its consumers.
// The generator owns the master modport; counter, display-mux and blink logic use slave.
interface clock_gen_if;
   logic EN;
   logic CLR;
   logic CLK_FAST;
   logic CLK_2HZ;
   logic CLK_1HZ;
   logic CLK_BLINK;
   logic TICK_2HZ;
   logic TICK_1HZ;

   modport master (
      input  EN, CLR,
      output CLK_FAST, CLK_2HZ, CLK_1HZ, CLK_BLINK, TICK_2HZ, TICK_1HZ
   );

   modport slave (
      output EN, CLR,
      input  CLK_FAST, CLK_2HZ, CLK_1HZ, CLK_BLINK, TICK_2HZ, TICK_1HZ
   );
endinterface

// File: rtl/clock_gen.sv
// Stopwatch clock generator: display-mux clock, aligned 2 Hz / 1 Hz square waves,
// programmable-duty blink clock and one-cycle tick strobes, all from CLK_REF.
module clock_gen #(
   parameter int REF_HZ   = 100000000,
   parameter int FAST_HZ  = 500,
   parameter int BLINK_ON = 2
) (
   input logic        CLK_REF,
   input logic        CLK_RES,
   clock_gen_if.master bus
);
   localparam int FAST_DIV = REF_HZ / (2 * FAST_HZ);
   localparam int Q_DIV    = REF_HZ / 4;
   localparam int FW       = (FAST_DIV > 1) ? $clog2(FAST_DIV) : 1;
   localparam int QW       = (Q_DIV > 1) ? $clog2(Q_DIV) : 1;
   localparam logic [FW-1:0] FAST_LAST = FW'((FAST_DIV > 0) ? FAST_DIV - 1 : 0);
   localparam logic [QW-1:0] Q_LAST    = QW'((Q_DIV > 0) ? Q_DIV - 1 : 0);
   localparam logic [2:0]    BLINK_PH  = 3'(BLINK_ON);

   if ((REF_HZ % 4 != 0) || (REF_HZ < 8) || (FAST_DIV < 1) ||
       (BLINK_ON < 1) || (BLINK_ON > 3)) begin : g_param_err
      $error("clock_gen: illegal parameters REF_HZ=%0d FAST_HZ=%0d BLINK_ON=%0d",
             REF_HZ, FAST_HZ, BLINK_ON);
   end

   logic [FW-1:0] fcnt;
   logic [QW-1:0] qcnt;
   logic [1:0]    ph;
   logic [1:0]    ph_next;
   logic          qtick;
   logic          fast_r;
   logic          hz2_r;
   logic          hz1_r;
   logic          blink_r;
   logic          tick2_r;
   logic          tick1_r;

   assign qtick   = bus.EN && (qcnt == Q_LAST);
   assign ph_next = ph + 2'd1;

   // Ticks are recomputed every edge so they never outlive one cycle, even across a pause.
   always_ff @(posedge CLK_REF or negedge CLK_RES) begin
      if (!CLK_RES) begin
         fcnt    <= '0;
         qcnt    <= '0;
         ph      <= '0;
         fast_r  <= 1'b0;
         hz2_r   <= 1'b0;
         hz1_r   <= 1'b0;
         blink_r <= 1'b0;
         tick2_r <= 1'b0;
         tick1_r <= 1'b0;
      end else if (bus.CLR) begin
         fcnt    <= '0;
         qcnt    <= '0;
         ph      <= '0;
         fast_r  <= 1'b0;
         hz2_r   <= 1'b0;
         hz1_r   <= 1'b0;
         blink_r <= 1'b0;
         tick2_r <= 1'b0;
         tick1_r <= 1'b0;
      end else begin
         tick2_r <= qtick && ph_next[0] && !ph[0];
         tick1_r <= qtick && ph_next[1] && !ph[1];
         if (bus.EN) begin
            if (fcnt == FAST_LAST) begin
               fcnt   <= '0;
               fast_r <= ~fast_r;
            end else begin
               fcnt <= fcnt + FW'(1);
            end
            if (qcnt == Q_LAST) qcnt <= '0;
            else                qcnt <= qcnt + QW'(1);
         end
         // Blink stays low until the first qtick because it is only ever loaded here.
         if (qtick) begin
            ph      <= ph_next;
            hz2_r   <= ph_next[0];
            hz1_r   <= ph_next[1];
            blink_r <= ({1'b0, ph_next} < BLINK_PH);
         end
      end
   end

   assign bus.CLK_FAST  = fast_r;
   assign bus.CLK_2HZ   = hz2_r;
   assign bus.CLK_1HZ   = hz1_r;
   assign bus.CLK_BLINK = blink_r;
   assign bus.TICK_2HZ  = tick2_r;
   assign bus.TICK_1HZ  = tick1_r;
endmodule

// File: tb/tb_clock_gen.sv
// Directed bench for clock_gen at REF_HZ=40, FAST_HZ=5 (FAST_DIV=4, Q_DIV=10),
// with three instances covering BLINK_ON = 1, 2 and 3.
module tb_clock_gen;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   clock_gen_if bus2 ();
   clock_gen_if bus1 ();
   clock_gen_if bus3 ();

   assign bus1.EN  = bus2.EN;
   assign bus1.CLR = bus2.CLR;
   assign bus3.EN  = bus2.EN;
   assign bus3.CLR = bus2.CLR;

   clock_gen #(.REF_HZ(40), .FAST_HZ(5), .BLINK_ON(2)) u_dut  (.CLK_REF(clk), .CLK_RES(rst_n), .bus(bus2));
   clock_gen #(.REF_HZ(40), .FAST_HZ(5), .BLINK_ON(1)) u_dut1 (.CLK_REF(clk), .CLK_RES(rst_n), .bus(bus1));
   clock_gen #(.REF_HZ(40), .FAST_HZ(5), .BLINK_ON(3)) u_dut3 (.CLK_REF(clk), .CLK_RES(rst_n), .bus(bus3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else             n_pass++;
   endtask

   // Expected {fast, 2hz, 1hz, blink, tick2, tick1} after edge e of an undisturbed run.
   function automatic logic [5:0] model(input int e, input int bon);
      int   q;
      logic fast, s2, s1, bl, t2, t1;
      q    = (e / 10) % 4;
      fast = ((e / 4) % 2) == 1;
      s2   = (q % 2) == 1;
      s1   = q >= 2;
      bl   = (e >= 10) && (q < bon);
      t2   = (e % 20) == 10;
      t1   = (e % 40) == 20;
      return {fast, s2, s1, bl, t2, t1};
   endfunction

   function automatic logic [5:0] obs();
      return {bus2.CLK_FAST, bus2.CLK_2HZ, bus2.CLK_1HZ, bus2.CLK_BLINK, bus2.TICK_2HZ, bus2.TICK_1HZ};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus2.EN  = 1'b1;
      bus2.CLR = 1'b0;
      rst_n    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset outputs", 32'(obs()), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_plain(input string name, input int last);
      int c1, c2, c3;
      c1 = 0; c2 = 0; c3 = 0;
      check($sformatf("%s e0", name), 32'(obs()), 32'd0);
      for (int e = 1; e <= last; e++) begin
         step();
         check($sformatf("%s e%0d", name, e), 32'(obs()), 32'(model(e, 2)));
         check($sformatf("%s blink1 e%0d", name, e), 32'(bus1.CLK_BLINK), 32'(model(e, 1) >> 2) & 32'd1);
         check($sformatf("%s blink3 e%0d", name, e), 32'(bus3.CLK_BLINK), 32'(model(e, 3) >> 2) & 32'd1);
         if (e >= 40 && e < 80) begin
            c1 += int'(bus1.CLK_BLINK);
            c2 += int'(bus2.CLK_BLINK);
            c3 += int'(bus3.CLK_BLINK);
         end
      end
      if (last >= 79) begin
         check($sformatf("%s blink1 high count", name), 32'(c1), 32'd10);
         check($sformatf("%s blink2 high count", name), 32'(c2), 32'd20);
         check($sformatf("%s blink3 high count", name), 32'(c3), 32'd30);
      end
   endtask

   task automatic run_pause(input int start, input int len, input int last);
      logic [5:0] exp;
      for (int e = 1; e <= last; e++) begin
         bus2.EN = !(e >= start && e < start + len);
         step();
         if (e < start)            exp = model(e, 2);
         else if (e < start + len) exp = model(start - 1, 2) & 6'b111100;
         else                      exp = model(e - len, 2);
         check($sformatf("pause%0d e%0d", start, e), 32'(obs()), 32'(exp));
      end
      bus2.EN = 1'b1;
   endtask

   task automatic run_clear(input int at, input int last);
      logic [5:0] exp;
      for (int e = 1; e <= last; e++) begin
         bus2.CLR = (e == at);
         step();
         exp = (e < at) ? model(e, 2) : model(e - at, 2);
         check($sformatf("clr e%0d", e), 32'(obs()), 32'(exp));
      end
      bus2.CLR = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b0;
      bus2.EN  = 1'b0;
      bus2.CLR = 1'b0;

      do_reset();
      run_plain("run", 80);

      do_reset();
      run_pause(15, 17, 60);

      do_reset();
      run_pause(11, 4, 40);

      do_reset();
      run_clear(25, 50);

      // Asynchronous reset in the middle of a TICK_1HZ cycle.
      do_reset();
      for (int e = 1; e <= 20; e++) step();
      check("tick1 before async reset", 32'(bus2.TICK_1HZ), 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      check("async reset outputs", 32'(obs()), 32'd0);
      check("async reset blink1", 32'(bus1.CLK_BLINK), 32'd0);
      check("async reset blink3", 32'(bus3.CLK_BLINK), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("held reset outputs", 32'(obs()), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_plain("rerun", 45);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/clock_gen.md
Name: clock_gen

Overview:
- Parametrised successor to the stopwatch's fixed 1 Hz/2 Hz divider.
- Derives a fast display-multiplex clock, phase-aligned 2 Hz and 1 Hz square waves, and a duty-programmable blink clock from one reference clock.
- Adds single-cycle tick strobes, a pause enable and a synchronous clear.
- Feeds the counter, display-mux and blink logic of the stopwatch top level.

Parameters:
- REF_HZ, 100000000: reference clock frequency in Hz. Must be a multiple of 4 and at least 8.
- FAST_HZ, 500: CLK_FAST output frequency. FAST_DIV = REF_HZ/(2*FAST_HZ), floor. Must be at least 1.
- BLINK_ON, 2: number of quarter-second phases (1..3) per second for which CLK_BLINK is high.

Ports:
- CLK_REF  input  1  reference clock. All logic is clocked on its rising edge.
- CLK_RES  input  1  asynchronous, active-low reset.
- EN  input  1  count enable. When 0, all counters and outputs hold.
- CLR  input  1  synchronous clear. Active high. Overrides EN.
- CLK_FAST  output  1  square wave at FAST_HZ.
- CLK_2HZ  output  1  2 Hz square wave, 50% duty.
- CLK_1HZ  output  1  1 Hz square wave, 50% duty, edge-aligned with CLK_2HZ.
- CLK_BLINK  output  1  1 Hz wave, high for BLINK_ON/4 of each period.
- TICK_2HZ  output  1  one-cycle pulse following each CLK_2HZ rising edge.
- TICK_1HZ  output  1  one-cycle pulse following each CLK_1HZ rising edge.

Behaviour:
- Reset: CLK_RES=0 forces all counters and every output to 0 immediately, without waiting for a clock edge. Counting resumes on the first CLK_REF edge after release.
- Clear: CLR=1 at an edge produces the same state as reset. CLR has priority over EN.
- All outputs are registers. No output is a combinational function of an input.
- Fast path:
  - fcnt runs 0..FAST_DIV-1 while EN=1. Width is $clog2(FAST_DIV), minimum 1.
  - At the edge where fcnt==FAST_DIV-1: fcnt wraps to 0 and CLK_FAST toggles.
  - Period is 2*FAST_DIV cycles.
- Quarter prescaler:
  - qcnt runs 0..Q_DIV-1 with Q_DIV = REF_HZ/4. Width is $clog2(Q_DIV).
  - Internal qtick is high while qcnt==Q_DIV-1 and EN=1.
- Phase counter:
  - ph is 2 bits and increments modulo 4 on qtick.
  - At the same edge: CLK_2HZ <= ph_next[0], CLK_1HZ <= ph_next[1], CLK_BLINK <= (ph_next < BLINK_ON).
  - Consequence: all three outputs change on the same edge, so there is no skew between them.
  - Exception: CLK_BLINK is held at 0 from reset until the first qtick.
- Edge timing from reset release (edge 1 = first edge):
  - CLK_2HZ rises at edge Q_DIV.
  - CLK_1HZ rises at edge 2*Q_DIV.
  - CLK_2HZ, CLK_1HZ and CLK_BLINK change only on qtick edges.
- Ticks:
  - TICK_2HZ <= 1 on an edge where ph_next[0] rises (0→1). It deasserts at the next edge.
  - TICK_1HZ <= 1 on an edge where ph_next[1] rises (ph goes 1→2).
  - Each tick is high for exactly one cycle. Both ticks are 0 while EN=0.
- EN=0:
  - fcnt, qcnt, ph and all square outputs hold their values.
  - Ticks drop to 0 at the next edge.
  - A tick already high when EN falls still lasts exactly its one cycle. No tick is ever stretched or duplicated.
- EN re-asserted: counting continues from the held counts. Phase relationships are preserved and there is no extra qtick.
- Wrap-around: fcnt, qcnt and ph wrap only at their terminal counts. They never overflow their width.
- Simultaneous events:
  - CLR and EN both high: clear wins.
  - The CLK_FAST toggle and a qtick falling on the same edge are independent; both take effect.
- Reset mid-operation: asserting CLK_RES at any point, including during a tick, returns all state to 0. No partial pulses appear after release.
- Elaboration: parameter violations (REF_HZ%4≠0, FAST_DIV<1, BLINK_ON outside 1..3) are flagged with an $error in a generate check.

Test Plan:
- Run with REF_HZ=40, FAST_HZ=5, BLINK_ON=2 (FAST_DIV=4, Q_DIV=10) for all scenarios.
- Reset release, EN=1 → CLK_FAST toggles every 4 edges. CLK_2HZ rises at edge 10 and falls at edge 20. CLK_1HZ rises at edge 20 and falls at edge 40. TICK_2HZ is high for the cycle after edges 10 and 30. TICK_1HZ is high only after edge 20 within 0..40.
- BLINK_ON=2 → CLK_BLINK is high from edge 10 to edge 20 and from edge 40 to edge 60, then low otherwise within each 40-cycle period. Rerun with BLINK_ON=1 and BLINK_ON=3 → high for 10 and 30 cycles per period respectively.
- EN=0 for 17 cycles starting at edge 15 → all outputs frozen and ticks 0 during the pause. Every subsequent edge is delayed by exactly 17 cycles, e.g. CLK_1HZ rises at edge 37.
- CLR pulse at edge 25 with EN=1 → all outputs 0 at edge 25. The next CLK_2HZ rise is at edge 35.
- Async reset asserted mid-cycle while TICK_1HZ=1 → all outputs 0 before the next CLK_REF edge. After release, timing repeats the first scenario exactly.
- Elaboration with REF_HZ=42 → $error reported and simulation stops.
